alu_issue_wb: RTL and testbench

Issue and writeback stage wrapped around the 32-bit registered ALU. It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal register file. It drives A/B/op into the ALU, holds them for the ALU's two-edge result/status timing, then writes the result back and latches the 5-bit status into a flags register. Exactly one instruction is in flight, so there are no data hazards.

---
 rtl/alu_issue_wb.sv | 133 +++++++++++++
 tb/tb_alu_issue_wb.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_wb.sv
// Issue/writeback stage around a two-edge registered 32-bit ALU.
// One instruction in flight: IDLE accepts, EX1/EX2 hold the ALU operands
// while the ALU samples them twice, WB commits result and status.
//
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both high; in_ready is high only in IDLE, and in_* are
// sampled only at the transfer edge. out_valid and err are one-cycle pulses.
module alu_issue_wb #(
    parameter int REG_COUNT = 8,
    parameter int ADDR_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic              in_imm_en,
    input  logic [31:0]       in_imm,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [3:0]        alu_op,
    input  logic [31:0]       alu_result,
    input  logic [4:0]        alu_status,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_rd,
    output logic [31:0]       out_data,
    output logic [4:0]        flags,
    output logic              err,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EX1  = 2'd1,
        EX2  = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t              state_q;
    logic [31:0]         regs_q [REG_COUNT];
    logic [31:0]         alu_a_q;
    logic [31:0]         alu_b_q;
    logic [3:0]          alu_op_q;
    logic [ADDR_W-1:0]   rd_q;
    logic                out_valid_q;
    logic [ADDR_W-1:0]   out_rd_q;
    logic [31:0]         out_data_q;
    logic [4:0]          flags_q;
    logic                err_q;

    logic [31:0]         rs1_val;
    logic [31:0]         rs2_val;
    logic                op_legal;

    // Opcodes the ALU implements; anything else is rejected with err.
    always_comb begin
        case (in_op)
            4'b0000, 4'b1000, 4'b0111, 4'b0110,
            4'b0100, 4'b0101, 4'b0011: op_legal = 1'b1;
            default:                   op_legal = 1'b0;
        endcase
    end

    // Register-file read ports; r0 is hardwired to zero.
    always_comb begin
        rs1_val  = (in_rs1 == '0)   ? 32'd0 : regs_q[in_rs1];
        rs2_val  = (in_rs2 == '0)   ? 32'd0 : regs_q[in_rs2];
        dbg_data = (dbg_addr == '0) ? 32'd0 : regs_q[dbg_addr];
    end

    // Issue/writeback FSM with register file and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= 32'd0;
            alu_a_q     <= 32'd0;
            alu_b_q     <= 32'd0;
            alu_op_q    <= 4'b0000;
            rd_q        <= '0;
            out_valid_q <= 1'b0;
            out_rd_q    <= '0;
            out_data_q  <= 32'd0;
            flags_q     <= 5'd0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (op_legal) begin
                            alu_a_q  <= rs1_val;
                            alu_b_q  <= in_imm_en ? in_imm : rs2_val;
                            alu_op_q <= in_op;
                            rd_q     <= in_rd;
                            state_q  <= EX1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                EX1: state_q <= EX2;
                EX2: state_q <= WB;
                WB: begin
                    if (rd_q != '0) regs_q[rd_q] <= alu_result;
                    flags_q     <= alu_status;
                    out_valid_q <= 1'b1;
                    out_rd_q    <= rd_q;
                    out_data_q  <= alu_result;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign out_valid = out_valid_q;
    assign out_rd    = out_rd_q;
    assign out_data  = out_data_q;
    assign flags     = flags_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: drives instructions, models an external two-edge
// ALU, and checks writebacks/err pulses against an architectural model.
module tb_alu_issue_wb;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SL  = 4'b0101;
    localparam logic [3:0] OP_SR  = 4'b0011;
    localparam int         EW     = 41;  // {is_err, rd[2:0], data[31:0], flags[4:0]}

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'b0;
    logic [2:0]  in_rd = 3'd0, in_rs1 = 3'd0, in_rs2 = 3'd0;
    logic        in_imm_en = 1'b0;
    logic [31:0] in_imm = 32'd0;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result = 32'd0;
    logic [4:0]  alu_status = 5'd0;
    logic        out_valid;
    logic [2:0]  out_rd;
    logic [31:0] out_data;
    logic [4:0]  flags;
    logic        err;
    logic [2:0]  dbg_addr = 3'd0;
    logic [31:0] dbg_data;
    logic [1:0]  dbg_state;

    alu_issue_wb #(.REG_COUNT(8), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm_en(in_imm_en), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_status(alu_status),
        .out_valid(out_valid), .out_rd(out_rd), .out_data(out_data),
        .flags(flags), .err(err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
    );

    // ---------------- ALU behaviour {status, result} ----------------
    function automatic logic [36:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        s = 33'd0; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            OP_SUB: begin
                r = a - b;
                c = (a < b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SL:   r = a << b[4:0];
            OP_SR:   r = a >> b[4:0];
            default: r = 32'd0;
        endcase
        return {v, r[31], (r == 32'd0), ^r, c, r};
    endfunction

    // External ALU: samples operands on every rising edge.
    always @(posedge clk) {alu_status, alu_result} <= alu_f(alu_a, alu_b, alu_op);

    // ---------------- architectural model ----------------
    logic [3:0]  legal_ops [7] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SL, OP_SR};
    logic [3:0]  bad_ops   [4] = '{4'b1111, 4'b0001, 4'b0010, 4'b1010};
    logic [31:0] m_regs [8];
    logic [4:0]  m_flags;

    function automatic bit is_legal(input logic [3:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q [$];
    int            cyc_q [$];
    int            n_vec = 0;
    int            n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model the effect of an instruction at its accept edge.
    task automatic model_accept();
        logic [31:0] a, b;
        logic [36:0] res;
        if (is_legal(in_op)) begin
            a   = m_regs[in_rs1];
            b   = in_imm_en ? in_imm : m_regs[in_rs2];
            res = alu_f(a, b, in_op);
            if (in_rd != 3'd0) m_regs[in_rd] = res[31:0];
            m_flags = res[36:32];
            exp_q.push_back({1'b0, in_rd, res[31:0], res[36:32]});
            cyc_q.push_back(cyc + 4);
        end else begin
            exp_q.push_back({1'b1, 40'd0});
            cyc_q.push_back(cyc + 1);
        end
    endtask

    // Monitor: compares every output pulse against the queue head.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        int            c;
        if (rst_n) begin
            if (out_valid && err) begin
                n_vec++; n_bad++;
                $display("FAIL pulse_overlap: out_valid and err both high at cycle %0d", cyc);
            end
            if (out_valid || err) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_output: out_valid=%0b err=%0b at cycle %0d", out_valid, err, cyc);
                end else begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    check("pulse_kind_err", 64'(err), 64'(e[40]));
                    check("pulse_cycle", 64'(cyc), 64'(c));
                    if (!e[40]) begin
                        check("out_rd", 64'(out_rd), 64'(e[39:37]));
                        check("out_data", 64'(out_data), 64'(e[36:5]));
                        check("flags", 64'(flags), 64'(e[4:0]));
                    end
                end
            end else if (cyc_q.size() > 0 && cyc_q[0] < cyc) begin
                n_vec++; n_bad++;
                $display("FAIL missing_output: expected at cycle %0d, none by cycle %0d", cyc_q[0], cyc);
                void'(exp_q.pop_front());
                void'(cyc_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                        input logic imm_en, input logic [31:0] imm, input bit hold,
                        output int waited);
        logic [31:0] tmp;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_imm_en = imm_en; in_imm = imm;
        tmp = rd;  in_rd  = tmp[2:0];
        tmp = rs1; in_rs1 = tmp[2:0];
        tmp = rs2; in_rs2 = tmp[2:0];
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_vec++; n_bad++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles", waited);
            in_valid = 1'b0;
            return;
        end
        model_accept();
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic chk_reg(input int i, input logic [31:0] exp);
        logic [31:0] tmp;
        tmp = i;
        dbg_addr = tmp[2:0];
        #1;
        check($sformatf("dbg_r%0d", i), 64'(dbg_data), 64'(exp));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          w;
        logic [4:0]  saved_flags;
        logic [3:0]  op;
        foreach (m_regs[i]) m_regs[i] = 32'd0;
        m_flags = 5'd0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_b", 64'(alu_b), 64'd0);
        check("rst_alu_op", 64'(alu_op), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // Immediate load then add to zero
        send(OP_ADD, 1, 0, 0, 1'b1, 32'd5, 1'b1, w);
        send(OP_ADD, 2, 1, 0, 1'b1, 32'hFFFF_FFFB, 1'b0, w);
        drain();
        check("imm_flags_zero_carry", 64'(flags), 64'(5'b00101));
        chk_reg(1, 32'd5);
        chk_reg(2, 32'd0);

        // Reset in the middle of EX2 discards the instruction
        send(OP_ADD, 3, 1, 0, 1'b1, 32'd7, 1'b0, w);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        foreach (m_regs[i]) m_regs[i] = 32'd0;
        m_flags = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        check("midrst_flags", 64'(flags), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 8; i++) chk_reg(i, 32'd0);
        repeat (6) @(negedge clk);

        // Register-register ops
        send(OP_ADD, 1, 0, 0, 1'b1, 32'h0F0F_0000, 1'b1, w);
        send(OP_ADD, 2, 0, 0, 1'b1, 32'h00FF_00FF, 1'b1, w);
        send(OP_XOR, 3, 1, 2, 1'b0, 32'd0, 1'b0, w);
        drain();
        chk_reg(3, 32'h0FF0_00FF);
        check("alu_op_before_sub", 64'(alu_op), 64'(OP_XOR));
        send(OP_SUB, 4, 2, 1, 1'b0, 32'hDEAD_BEEF, 1'b0, w);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("sub_alu_op_hold%0d", k), 64'(alu_op), 64'(OP_SUB));
            check($sformatf("sub_in_ready_low%0d", k), 64'(in_ready), 64'd0);
        end
        drain();
        chk_reg(4, 32'hF1F0_00FF);
        check("sub_flag_neg", 64'(flags[3]), 64'd1);

        // Shifts
        send(OP_ADD, 5, 0, 0, 1'b1, 32'h8000_0001, 1'b1, w);
        send(OP_SL, 6, 5, 0, 1'b1, 32'd1, 1'b1, w);
        send(OP_SR, 7, 5, 0, 1'b1, 32'd1, 1'b0, w);
        drain();
        chk_reg(6, 32'h0000_0002);
        chk_reg(7, 32'h4000_0000);

        // Illegal opcode
        saved_flags = flags;
        send(4'b1111, 3, 1, 2, 1'b0, 32'd0, 1'b0, w);
        @(negedge clk);
        check("illegal_in_ready", 64'(in_ready), 64'd1);
        drain();
        check("illegal_flags_kept", 64'(flags), 64'(saved_flags));
        chk_reg(3, 32'h0FF0_00FF);

        // Back-to-back with r0 destination
        send(OP_ADD, 0, 0, 0, 1'b1, 32'h0000_1234, 1'b1, w);
        send(OP_ADD, 6, 0, 0, 1'b1, 32'h0000_0055, 1'b0, w);
        check("b2b_ready_low_cycles", 64'(w), 64'd3);
        drain();
        chk_reg(0, 32'd0);
        chk_reg(6, 32'h0000_0055);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_op  = 4'($urandom);
                in_imm = $urandom;
                in_rd  = 3'($urandom);
            end
            if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 3)];
            else                           op = legal_ops[$urandom_range(0, 6)];
            send(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                 1'($urandom_range(0, 1)), w);
        end
        drain();
        for (int i = 0; i < 8; i++) chk_reg(i, m_regs[i]);
        check("final_flags", 64'(flags), 64'(m_flags));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
